// File: rtl/bch_enc.sv
// ---------------------------------------------------------------------------
// bch_enc -- systematic binary BCH encoder, 8 code bits per 64-bit word.
//
// Supported codes (selected per frame by `code`):
//   1: (63,51)    t=2  GF(2^6)  x^6+x+1
//   2: (255,239)  t=2  GF(2^8)  x^8+x^4+x^3+x^2+1
//   3: (1023,983) t=4  GF(2^10) x^10+x^3+1
// g(x) is the product of the minimal polynomials of a^1,a^3[,a^5,a^7]; it is
// built at elaboration time from the field polynomial.
//
// Word layout: word w covers code positions base=n-8w down to base-7; byte j
// bit HARD_BIT carries position base-7+j, all other bits are zero on output.
// Position n is a pad bit (ignored on input, 0 on output).
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   set, code              frame start pulse and code select (0 is illegal)
//   busy                   frame in progress
//   in_valid/in_ready      message word handshake, idata
//   out_valid/out_ready    codeword word handshake, odata, out_last
// ---------------------------------------------------------------------------
module bch_enc #(
  parameter int LANES    = 8,
  parameter int HARD_BIT = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set,
  input  logic [1:0]           code,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   idata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   odata,
  output logic                 out_last
);

  localparam int W    = 8 * LANES;
  localparam int RMAX = 40;

  typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

  // GF(2^m) multiply, shift-and-add with reduction by the field polynomial.
  function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b,
                                        input int m, input logic [10:0] prim);
    logic [10:0] p;
    p = '0;
    for (int i = m - 1; i >= 0; i--) begin
      p = p << 1;
      if (((p >> m) & 11'd1) != 11'd0) p = p ^ prim;
      if (((b >> i) & 10'd1) != 10'd0) p = p ^ {1'b0, a};
    end
    return p[9:0];
  endfunction

  // Multiply out (x + beta) over every conjugate of a^1, a^3, ... a^(2t-1).
  // The result has binary coefficients; bits [RMAX-1:0] are returned, the
  // leading x^r term is implied by the code's degree.
  function automatic logic [RMAX-1:0] gen_poly(input int m, input logic [10:0] prim,
                                               input int t);
    logic [9:0]      c [0:RMAX];
    logic [9:0]      beta;
    logic [RMAX-1:0] g;
    for (int d = 0; d <= RMAX; d++) c[d] = '0;
    c[0] = 10'd1;
    for (int k = 0; k < t; k++) begin
      beta = 10'd1;
      for (int e = 0; e < 2 * k + 1; e++) beta = gf_mul(beta, 10'd2, m, prim);
      for (int s = 0; s < m; s++) begin
        for (int d = RMAX; d >= 1; d--) c[d] = c[d-1] ^ gf_mul(c[d], beta, m, prim);
        c[0] = gf_mul(c[0], beta, m, prim);
        beta = gf_mul(beta, beta, m, prim);
      end
    end
    for (int d = 0; d < RMAX; d++) g[d] = c[d][0];
    return g;
  endfunction

  localparam logic [RMAX-1:0] G1 = gen_poly(6,  11'h043, 2);
  localparam logic [RMAX-1:0] G2 = gen_poly(8,  11'h11D, 2);
  localparam logic [RMAX-1:0] G3 = gen_poly(10, 11'h409, 4);

  function automatic logic [5:0] code_r(input logic [1:0] c);
    case (c)
      2'd2:    return 6'd16;
      2'd3:    return 6'd40;
      default: return 6'd12;
    endcase
  endfunction

  function automatic logic [10:0] code_n(input logic [1:0] c);
    case (c)
      2'd2:    return 11'd255;
      2'd3:    return 11'd1023;
      default: return 11'd63;
    endcase
  endfunction

  function automatic logic [RMAX-1:0] code_g(input logic [1:0] c);
    case (c)
      2'd2:    return G2;
      2'd3:    return G3;
      default: return G1;
    endcase
  endfunction

  // One bit of m(x)*x^r mod g(x): the incoming bit is compared with the
  // remainder MSB, then the remainder shifts and conditionally folds g(x).
  function automatic logic [RMAX-1:0] lfsr_bit(input logic [RMAX-1:0] s, input logic b,
                                               input logic [5:0] r, input logic [RMAX-1:0] g);
    logic [RMAX-1:0] mask;
    logic [RMAX-1:0] top;
    logic [RMAX-1:0] nx;
    logic            fb;
    mask = (RMAX'(1) << r) - RMAX'(1);
    top  = RMAX'(1) << (r - 6'd1);
    fb   = b ^ (|(s & top));
    nx   = (s << 1) & mask;
    if (fb) nx = nx ^ (g & mask);
    return nx;
  endfunction

  state_t          state, state_next;
  logic [1:0]      code_q;
  logic [RMAX-1:0] rem, rem_abs;
  logic [10:0]     pos;          // base position of the next word to load
  logic [W-1:0]    word;
  logic [5:0]      r_cur;
  logic [10:0]     n_cur;
  logic [RMAX-1:0] g_cur;
  logic [10:0]     p;
  logic            free, load, start, last_msg;
  logic            unused_idata;

  assign unused_idata = ^idata;
  assign free         = !out_valid || out_ready;
  assign busy         = (state != IDLE);
  assign last_msg     = pos < (11'(r_cur) + 11'd8);

  // Absorb the word's message bits MSB-first, then assemble the output word
  // from the message bits and the post-absorb remainder.  In PAR every
  // position is below r, so nothing is absorbed and rem_abs equals rem.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    r_cur   = code_r(code_q);
    n_cur   = code_n(code_q);
    g_cur   = code_g(code_q);
    rem_abs = rem;
    word    = '0;
    p       = '0;
    for (int j = LANES - 1; j >= 0; j--) begin
      p = pos - 11'd7 + 11'(j);
      if (p < n_cur && p >= 11'(r_cur))
        rem_abs = lfsr_bit(rem_abs, idata[8*j+HARD_BIT], r_cur, g_cur);
    end
    for (int j = 0; j < LANES; j++) begin
      p = pos - 11'd7 + 11'(j);
      if (p == n_cur)             word[8*j+HARD_BIT] = 1'b0;
      else if (p >= 11'(r_cur))   word[8*j+HARD_BIT] = idata[8*j+HARD_BIT];
      else                        word[8*j+HARD_BIT] = rem_abs[p[5:0]];
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    load       = 1'b0;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (set && code != 2'd0) begin
          start      = 1'b1;
          state_next = MSG;
        end
      end
      MSG: begin
        in_ready = free;
        if (in_valid && free) begin
          load = 1'b1;
          if (last_msg) state_next = PAR;
        end
      end
      PAR: begin
        if (free) begin
          // Final word is leaving this edge: the frame is done.
          if (out_valid && out_last) state_next = IDLE;
          else                       load       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state     <= IDLE;
      code_q    <= '0;
      rem       <= '0;
      pos       <= '0;
      odata     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        code_q <= code;
        rem    <= '0;
        pos    <= code_n(code);
      end
      if (load) begin
        odata     <= word;
        out_valid <= 1'b1;
        out_last  <= (pos == 11'd7);
        pos       <= pos - 11'd8;
        rem       <= rem_abs;
      end else if (free) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bch_enc.sv
// ---------------------------------------------------------------------------
// tb_bch_enc -- self-checking bench for bch_enc.
// Expected codewords: message and pad bits come from the bench's own frame
// image; parity for code 1 comes from long division by the known generator
// 0x1539, and for every code the received codeword must evaluate to zero at
// a^1..a^2t (all syndromes zero).
// ---------------------------------------------------------------------------
module tb_bch_enc;

  logic        clk;
  logic        rst, set, in_valid, out_ready;
  logic        busy, in_ready, out_valid, out_last;
  logic [1:0]  code;
  logic [63:0] idata, odata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bch_enc #(.LANES(8), .HARD_BIT(7)) dut (
    .clk(clk), .rst(rst), .set(set), .code(code), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .idata(idata),
    .out_valid(out_valid), .out_ready(out_ready), .odata(odata),
    .out_last(out_last)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  bit cw [0:1023];   // expected codeword, index = code position
  bit rx [0:1023];   // received codeword
  bit par_known;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int gmul(input int a, input int b, input int m, input int prim);
    int pr = 0;
    for (int i = m - 1; i >= 0; i--) begin
      pr = pr << 1;
      if (((pr >> m) & 1) == 1) pr = pr ^ prim;
      if (((b >> i) & 1) == 1) pr = pr ^ a;
    end
    return pr;
  endfunction

  function automatic int c_n(input int cd);
    return (cd == 1) ? 63 : (cd == 2) ? 255 : 1023;
  endfunction
  function automatic int c_r(input int cd);
    return (cd == 1) ? 12 : (cd == 2) ? 16 : 40;
  endfunction
  function automatic int c_m(input int cd);
    return (cd == 1) ? 6 : (cd == 2) ? 8 : 10;
  endfunction
  function automatic int c_prim(input int cd);
    return (cd == 1) ? 'h43 : (cd == 2) ? 'h11D : 'h409;
  endfunction
  function automatic int c_t(input int cd);
    return (cd == 3) ? 4 : 2;
  endfunction

  // mode 0: all-zero message, 1: only position 62 set, 2: random message.
  task automatic build_msg(input int cd, input int mode);
    int n = c_n(cd);
    int r = c_r(cd);
    bit d [0:62];
    for (int q = 0; q <= 1023; q++) cw[q] = 1'b0;
    for (int q = r; q < n; q++)
      cw[q] = (mode == 2) ? ($urandom_range(0, 1) == 1) : (mode == 1 && q == 62);
    par_known = (cd == 1);
    if (cd == 1) begin
      for (int q = 0; q <= 62; q++) d[q] = cw[q];
      for (int q = 62; q >= 12; q--)
        if (d[q])
          for (int k = 0; k <= 12; k++) d[q-12+k] ^= (((32'h1539 >> k) & 1) == 1);
      for (int q = 0; q < 12; q++) cw[q] = d[q];
    end
  endtask

  function automatic logic [63:0] pack_word(input int n, input int r, input int wi);
    logic [63:0] v;
    int base = n - 8 * wi;
    for (int j = 0; j < 8; j++) begin
      int q = base - 7 + j;
      v[8*j +: 8] = 8'($urandom);
      if (q < n && q >= r) v[8*j+7] = cw[q];
    end
    return v;
  endfunction

  task automatic run_frame(input int cd, input int mode, input bit bp, input bit poke,
                           input int abort_at);
    int n    = c_n(cd);
    int r    = c_r(cd);
    int outw = (n + 1) / 8;
    int inw  = 0;
    int wi   = 0;
    int wo   = 0;
    int cyc  = 0;
    logic [63:0] expv, mask;
    for (int w = 0; w < outw; w++) if (n - 8 * w >= r) inw++;
    build_msg(cd, mode);

    set  = 1'b1;
    code = 2'(cd);
    tick();
    set  = 1'b0;
    check("busy_after_set", 64'(busy), 64'd1);

    while (wo < outw && cyc < 4000 && !(abort_at >= 0 && wo == abort_at)) begin
      in_valid  = (wi < inw) && (!bp || $urandom_range(0, 1) == 1);
      idata     = pack_word(n, r, wi);
      out_ready = !bp || ($urandom_range(0, 1) == 1);
      set       = poke && (cyc == 3);
      code      = set ? 2'd3 : 2'(cd);
      #1;
      if (poke && cyc == 4) check("busy_set_ignored", 64'(busy), 64'd1);
      if (in_valid && in_ready) wi++;
      if (out_valid && out_ready) begin
        int base = n - 8 * wo;
        expv = '0;
        mask = '0;
        for (int j = 0; j < 8; j++) begin
          int q = base - 7 + j;
          mask[8*j +: 7] = 7'h7F;
          if (q == n) begin
            mask[8*j+7] = 1'b1;
          end else begin
            rx[q] = odata[8*j+7];
            if (q >= r || par_known) begin
              mask[8*j+7] = 1'b1;
              expv[8*j+7] = cw[q];
            end
          end
        end
        check($sformatf("word%0d", wo), odata & mask, expv);
        check($sformatf("last%0d", wo), 64'(out_last), 64'(wo == outw - 1));
        wo++;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set       = 1'b0;

    if (abort_at < 0) begin
      check("words_out", 64'(wo), 64'(outw));
      check("words_in", 64'(wi), 64'(inw));
      check("busy_end", 64'(busy), 64'd0);
      for (int i = 1; i <= 2 * c_t(cd); i++) begin
        int beta = 1;
        int s    = 0;
        for (int e = 0; e < i; e++) beta = gmul(beta, 2, c_m(cd), c_prim(cd));
        for (int q = n - 1; q >= 0; q--) s = gmul(s, beta, c_m(cd), c_prim(cd)) ^ int'(rx[q]);
        check($sformatf("syndrome%0d", i), 64'(s), 64'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; set = 1'b0; code = 2'd0; in_valid = 1'b0; out_ready = 1'b1; idata = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_odata", odata, 64'd0);
    rst = 1'b0;
    tick();

    // Illegal code must not start a frame.
    set  = 1'b1;
    code = 2'd0;
    tick();
    set  = 1'b0;
    check("code0_busy", 64'(busy), 64'd0);
    check("code0_in_ready", 64'(in_ready), 64'd0);

    run_frame(1, 0, 1'b0, 1'b0, -1);   // all-zero message
    run_frame(1, 1, 1'b0, 1'b1, -1);   // x^62, with set pulsed mid-frame
    run_frame(2, 2, 1'b1, 1'b0, -1);   // random, 50% backpressure
    run_frame(3, 2, 1'b0, 1'b0, -1);   // random, full rate

    // Reset in the middle of a code-3 frame.
    run_frame(3, 2, 1'b0, 1'b0, 40);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_last", 64'(out_last), 64'd0);
    check("abort_odata", odata, 64'd0);
    rst = 1'b0;
    tick();
    run_frame(1, 2, 1'b1, 1'b0, -1);   // clean frame after abort

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
